// File: rtl/io_defs.sv
// rtl/io_defs.sv - shared constants for the I/O page decode of io_mmio_bridge
package io_defs;

    localparam int BYTE_W = 8;
    localparam int RAM_AW = 17;

    // cpu_a[17:16] value that selects the I/O page
    localparam logic [1:0] IO_PAGE = 2'b11;

    // I/O register offsets within the page (cpu_a[3:0])
    localparam logic [3:0] OFF_DATA  = 4'h0;
    localparam logic [3:0] OFF_CNT   = 4'h4;
    localparam logic [3:0] OFF_SNAP1 = 4'h5;
    localparam logic [3:0] OFF_SNAP2 = 4'h6;
    localparam logic [3:0] OFF_SNAP3 = 4'h7;
    localparam logic [3:0] OFF_OVF   = 4'h8;

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - synchronous byte FIFO feeding the UART transmitter
module io_tx_fifo
    import io_defs::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                i_push,
    input  logic [BYTE_W-1:0]   i_push_data,
    input  logic                i_pop,
    output logic [BYTE_W-1:0]   o_head,
    output logic                o_empty,
    output logic                o_full,
    output logic [DEPTH_LOG:0]  o_count_next,
    output logic                o_dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_V = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [BYTE_W-1:0]  r_mem [DEPTH];
    logic [DEPTH_LOG:0] r_wr_ptr;
    logic [DEPTH_LOG:0] r_rd_ptr;
    logic [DEPTH_LOG:0] w_count;
    logic               w_do_pop;
    logic               w_do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (w_count == '0);
    assign o_full    = (w_count == DEPTH_V);
    // Pop is resolved first so a full FIFO can still accept a byte in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dropped = i_push & ~w_do_push;
    assign o_head    = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];
    assign o_count_next = w_count + {{DEPTH_LOG{1'b0}}, w_do_push}
                                  - {{DEPTH_LOG{1'b0}}, w_do_pop};

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= i_push_data;
        end
    end

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/io_mmio_bridge.sv
// rtl/io_mmio_bridge.sv - CPU byte-port bridge to RAM and I/O page (option: IO_TX_OVERFLOW_CNT_EN)
module io_mmio_bridge
    import io_defs::*;
#(
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [31:0]         cpu_a,
    input  logic [BYTE_W-1:0]   cpu_dout,
    input  logic                cpu_wr,
    output logic [BYTE_W-1:0]   cpu_din,
    output logic                io_buffer_full,
    output logic [RAM_AW-1:0]   ram_a,
    output logic [BYTE_W-1:0]   ram_din,
    output logic                ram_we,
    input  logic [BYTE_W-1:0]   ram_dout,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_data,
    output logic                rx_pop,
    output logic                tx_valid,
    output logic [BYTE_W-1:0]   tx_data,
    input  logic                tx_ready,
    output logic                prog_stop
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] FULL_THRESH = (TX_DEPTH_LOG+1)'(TX_DEPTH - FULL_MARGIN);

    logic                   w_io;
    logic [3:0]             w_off;
    logic                   w_io_rd;
    logic                   w_io_wr;
    logic                   w_push;
    logic [BYTE_W-1:0]      w_push_data;
    logic [BYTE_W-1:0]      w_rdata;
    logic                   w_tx_empty;
    logic                   w_tx_full;
    logic [TX_DEPTH_LOG:0]  w_count_next;
    logic                   w_dropped;
    logic                   w_unused;

    logic                   r_sel_io;
    logic [3:0]             r_io_off;
    logic [BYTE_W-1:0]      r_io_rdata;
    logic [31:0]            r_cycle_cnt;
    logic [31:0]            r_snap;
    logic                   r_stop_pend;
    logic                   r_prog_stop;
    logic                   r_buffer_full;

    assign w_io    = (cpu_a[17:16] == IO_PAGE);
    assign w_off   = cpu_a[3:0];
    assign w_io_rd = rdy_in & w_io & ~cpu_wr;
    assign w_io_wr = rdy_in & w_io & cpu_wr;

    assign ram_a   = cpu_a[RAM_AW-1:0];
    assign ram_din = cpu_dout;
    assign ram_we  = cpu_wr & ~w_io & rdy_in;

    // A zero byte on the data port is a no-op; the stop port queues a 0x00 marker instead.
    assign w_push      = w_io_wr & (((w_off == OFF_DATA) & (cpu_dout != '0)) | (w_off == OFF_CNT));
    assign w_push_data = (w_off == OFF_CNT) ? '0 : cpu_dout;
    assign rx_pop      = ~rst_in & w_io_rd & (w_off == OFF_DATA) & rx_valid;

    assign cpu_din        = r_sel_io ? r_io_rdata : ram_dout;
    assign tx_valid       = ~w_tx_empty;
    assign prog_stop      = r_prog_stop;
    assign io_buffer_full = r_buffer_full;

    io_tx_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .i_push       (w_push),
        .i_push_data  (w_push_data),
        .i_pop        (tx_ready),
        .o_head       (tx_data),
        .o_empty      (w_tx_empty),
        .o_full       (w_tx_full),
        .o_count_next (w_count_next),
        .o_dropped    (w_dropped)
    );

`ifdef IO_TX_OVERFLOW_CNT_EN
    logic [BYTE_W-1:0] r_ovf_cnt;

    // Saturating count of bytes lost to a full TX FIFO.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ovf_cnt <= '0;
        end else if (w_dropped && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign w_unused = ^{cpu_a[31:18], cpu_a[15:4], r_io_off, w_tx_full};
`else
    assign w_unused = ^{cpu_a[31:18], cpu_a[15:4], r_io_off, w_tx_full, w_dropped};
`endif

    // I/O read data for the current request; writes and unmapped offsets read as zero.
    always_comb begin
        w_rdata = '0;
        if (!cpu_wr) begin
            case (w_off)
                OFF_DATA:  w_rdata = rx_valid ? rx_data : '0;
                OFF_CNT:   w_rdata = r_cycle_cnt[7:0];
                OFF_SNAP1: w_rdata = r_snap[15:8];
                OFF_SNAP2: w_rdata = r_snap[23:16];
                OFF_SNAP3: w_rdata = r_snap[31:24];
`ifdef IO_TX_OVERFLOW_CNT_EN
                OFF_OVF:   w_rdata = r_ovf_cnt;
`endif
                default:   w_rdata = '0;
            endcase
        end
    end

    // Request register: gives the one-cycle read latency and freezes with the CPU.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_io   <= 1'b1;
            r_io_off   <= '0;
            r_io_rdata <= '0;
        end else if (rdy_in) begin
            r_sel_io   <= w_io;
            r_io_off   <= w_off;
            r_io_rdata <= w_rdata;
        end
    end

    // Free-running cycle counter plus the snapshot taken when its low byte is read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cycle_cnt <= '0;
            r_snap      <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_io_rd && (w_off == OFF_CNT)) r_snap <= r_cycle_cnt;
        end
    end

    // Stop handshake: sticky stop once the requested stop has drained out of the FIFO.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stop_pend   <= 1'b0;
            r_prog_stop   <= 1'b0;
            r_buffer_full <= 1'b0;
        end else begin
            if (w_io_wr && (w_off == OFF_CNT)) r_stop_pend <= 1'b1;
            if (r_stop_pend && w_tx_empty)     r_prog_stop <= 1'b1;
            r_buffer_full <= (w_count_next >= FULL_THRESH);
        end
    end

endmodule

// File: tb/tb_io_mmio_bridge.sv
// tb/tb_io_mmio_bridge.sv - directed scoreboard bench for io_mmio_bridge
module tb_io_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    logic [7:0]  ram_mem [0:131071];
    logic [31:0] tb_cnt;
    logic [7:0]  rdq [$];
    logic [7:0]  txq [$];
    int          cmp_cnt = 0;
    int          bad_cnt = 0;

    always #5 clk = ~clk;

    io_mmio_bridge #(.TX_DEPTH_LOG(4), .FULL_MARGIN(2)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_dout       (ram_dout),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pop         (rx_pop),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .prog_stop      (prog_stop)
    );

    // Synchronous RAM model: registered read, one cycle latency
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    // Reference cycle counter
    always @(posedge clk) tb_cnt <= rst_in ? 32'd0 : tb_cnt + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX scoreboard: every accepted byte must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst_in && tx_valid && tx_ready) begin
            cmp_cnt++;
            assert (txq.size() != 0) else begin
                bad_cnt++;
                $error("FAIL tx_extra: observed %0h expected none", tx_data);
            end
            if (txq.size() != 0) check("tx_data", tx_data, txq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = 1'b1;
        cpu_dout = d;
        step();
        set_idle();
    endtask

    task automatic cpu_read(input string tag, input logic [31:0] a, input logic [7:0] exp, input logic exp_pop);
        cpu_a  = a;
        cpu_wr = 1'b0;
        #3;
        check({tag, "_pop"}, rx_pop, exp_pop);
        rdq.push_back(exp);
        step();
        set_idle();
        check(tag, cpu_din, rdq.pop_front());
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!tx_valid) break;
            step();
        end
        check(tag, tx_valid, 1'b0);
        check({tag, "_sb"}, txq.size(), 0);
    endtask

    logic [31:0] snap;
    logic        found;

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h0;
        tx_ready = 1'b0;
        set_idle();
        repeat (3) step();
        check("rst_cpu_din", cpu_din, 8'h00);
        check("rst_rx_pop", rx_pop, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_prog_stop", prog_stop, 1'b0);
        check("rst_buf_full", io_buffer_full, 1'b0);
        rst_in = 1'b0;

        // RAM write then read back
        cpu_a = 32'h100; cpu_wr = 1'b1; cpu_dout = 8'h55;
        #3;
        check("ram_we_wr", ram_we, 1'b1);
        check("ram_a_wr", ram_a, 17'h100);
        step();
        set_idle();
        #3;
        check("ram_we_idle", ram_we, 1'b0);
        cpu_read("ram_rd", 32'h100, 8'h55, 1'b0);

        // CPU frozen: no RAM write, no FIFO push
        rdy_in = 1'b0;
        cpu_a = 32'h200; cpu_wr = 1'b1; cpu_dout = 8'h99;
        #3;
        check("frozen_ram_we", ram_we, 1'b0);
        cpu_a = 32'h30000; cpu_dout = 8'h77;
        step();
        rdy_in = 1'b1;
        set_idle();
        check("frozen_no_push", tx_valid, 1'b0);

        // RX read with and without a byte available
        rx_valid = 1'b1; rx_data = 8'h41;
        cpu_read("rx_rd", 32'h30000, 8'h41, 1'b1);
        rx_valid = 1'b0; rx_data = 8'h00;
        cpu_read("rx_empty", 32'h30000, 8'h00, 1'b0);
        cpu_read("io_other", 32'h3000C, 8'h00, 1'b0);

        // TX: 'H', 'i', then an ignored 0x00
        tx_ready = 1'b1;
        txq.push_back(8'h48); cpu_write(32'h30000, 8'h48);
        txq.push_back(8'h69); cpu_write(32'h30000, 8'h69);
        cpu_write(32'h30000, 8'h00);
        repeat (4) step();
        wait_drain("tx_hi");

        // Counter snapshot across 0xFF -> 0x100
        for (int i = 0; i < 400 && tb_cnt != 32'hFF; i++) step();
        check("cnt_align", tb_cnt, 32'hFF);
        cpu_read("cnt_b0", 32'h30004, 8'hFF, 1'b0);
        cpu_read("snap_b1", 32'h30005, 8'h00, 1'b0);
        cpu_read("snap_b2", 32'h30006, 8'h00, 1'b0);
        cpu_read("snap_b3", 32'h30007, 8'h00, 1'b0);
        snap = tb_cnt;
        cpu_read("cnt2_b0", 32'h30004, snap[7:0], 1'b0);
        cpu_read("snap2_b1", 32'h30005, snap[15:8], 1'b0);

        // Fill FIFO with tx held off; watch the near-full flag
        tx_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            txq.push_back(8'(k));
            cpu_write(32'h30000, 8'(k));
            check($sformatf("buf_full_%0d", k), io_buffer_full, (k >= 14));
        end
        cpu_write(32'h30000, 8'hAA);
        check("buf_full_drop", io_buffer_full, 1'b1);
        // Push and pop together on a full FIFO: push must succeed
        tx_ready = 1'b1;
        txq.push_back(8'hBB);
        cpu_write(32'h30000, 8'hBB);
        check("buf_full_pushpop", io_buffer_full, 1'b1);
`ifdef IO_TX_OVERFLOW_CNT_EN
        cpu_read("ovf_cnt", 32'h30008, 8'h01, 1'b0);
`else
        cpu_read("ovf_cnt", 32'h30008, 8'h00, 1'b0);
`endif
        wait_drain("tx_full");
        check("buf_full_after", io_buffer_full, 1'b0);

        // Program stop behind three queued bytes
        tx_ready = 1'b0;
        txq.push_back(8'h31); cpu_write(32'h30000, 8'h31);
        txq.push_back(8'h32); cpu_write(32'h30000, 8'h32);
        txq.push_back(8'h33); cpu_write(32'h30000, 8'h33);
        txq.push_back(8'h00); cpu_write(32'h30004, 8'h5A);
        check("stop_pending", prog_stop, 1'b0);
        tx_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h00) begin
                found = 1'b1;
                break;
            end
        end
        check("stop_seen", found, 1'b1);
        step();
        check("stop_at_pop", prog_stop, 1'b0);
        check("stop_fifo_empty", tx_valid, 1'b0);
        step();
        check("stop_rise", prog_stop, 1'b1);
        repeat (3) step();
        check("stop_sticky", prog_stop, 1'b1);

        // Reset mid-drain flushes the FIFO and clears stop
        tx_ready = 1'b0;
        txq.push_back(8'h50); cpu_write(32'h30000, 8'h50);
        check("pre_rst_valid", tx_valid, 1'b1);
        rst_in = 1'b1;
        txq.delete();
        step();
        check("rst2_prog_stop", prog_stop, 1'b0);
        check("rst2_tx_valid", tx_valid, 1'b0);
        check("rst2_cpu_din", cpu_din, 8'h00);
        rst_in = 1'b0;
        tx_ready = 1'b1;
        repeat (3) step();
        check("rst2_flushed", tx_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/io_mmio_bridge.md
# io_mmio_bridge

Memory-mapped bus bridge downstream of the CPU core's byte-wide memory port. It decodes each CPU access as either the 128 KB RAM or the I/O page (`cpu_a[17:16]==2'b11`). It services the UART RX/TX, the cycle counter and the program-stop port, and returns read data one cycle after the request. A TX FIFO decouples CPU stores from the UART, and the bridge generates `io_buffer_full` back to the core.

## Interface
Parameters:
- `TX_DEPTH_LOG`, 4: TX FIFO holds 2^TX_DEPTH_LOG bytes.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free slots ≤ FULL_MARGIN.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: low = CPU port frozen.
- `cpu_a` in 32: CPU address; only bits [17:0] are decoded.
- `cpu_dout` in 8: CPU write data.
- `cpu_wr` in 1: 1 = write.
- `cpu_din` out 8: read data, valid the cycle after the request.
- `io_buffer_full` out 1: TX near full.
- `ram_a` out 17: RAM address.
- `ram_din` out 8: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in 8: RAM read data, valid next cycle.
- `rx_valid` in 1: RX byte available.
- `rx_data` in 8: RX byte.
- `rx_pop` out 1: consume one RX byte.
- `tx_valid` out 1: TX byte available.
- `tx_data` out 8: TX byte.
- `tx_ready` in 1: UART accepts the byte.
- `prog_stop` out 1: sticky; program finished and TX drained.

## Operation
- Decode: io = `cpu_a[17:16]==2'b11`. `ram_a = cpu_a[16:0]`, `ram_din = cpu_dout`, `ram_we = cpu_wr & ~io & rdy_in`.
- Request register (`sel_io`, `io_off[3:0]`, `io_rdata[7:0]`) is captured each cycle when `rdy_in`=1. `cpu_din = sel_io ? io_rdata : ram_dout`.
- Read 0x30000:
  - If `rx_valid`: `io_rdata` = `rx_data`, and `rx_pop` pulses for one cycle.
  - Otherwise `io_rdata` = 0x00 and there is no pop.
- Read 0x30004: returns `cycle_cnt[7:0]` and snapshots `cycle_cnt` into `snap`. Reads of 0x30005/6/7 return `snap` bytes 1/2/3.
- Other I/O reads return 0x00. Other I/O writes are ignored.
- Write 0x30000:
  - Nonzero byte: pushed into the TX FIFO.
  - 0x00: ignored.
  - Push while FIFO full: byte dropped.
- Write 0x30004: pushes 0x00 into the TX FIFO and sets `stop_pend`. `prog_stop` sets when `stop_pend` is set and the FIFO is empty; it stays set until reset.
- TX: `tx_valid` = FIFO non-empty; `tx_data` = head. Pop when `tx_valid & tx_ready`.
- `cycle_cnt` is 32 bits, +1 every clock after reset, independent of `rdy_in`, wraps modulo 2^32.
- `rdy_in`=0: no RAM write, no RX pop, no FIFO push, request register held. TX drain and `cycle_cnt` continue.

## Timing
- Reset values: `cpu_din`=0 (`sel_io`=1, `io_rdata`=0); `rx_pop`=0; `tx_valid`=0; `prog_stop`=0; `io_buffer_full`=0; `cycle_cnt`=0; `snap`=0; `stop_pend`=0; FIFO empty.
- Read latency is exactly 1 cycle for both RAM and I/O. Writes complete in the request cycle.
- FIFO wrap: pointers are TX_DEPTH_LOG+1 bits.
- Push and pop in the same cycle on a full FIFO:
  - Pop is evaluated first, so the push succeeds and the count is unchanged.
  - On an empty FIFO, the pushed byte is not visible until the next cycle.
- `io_buffer_full` is registered: `count_next ≥ 2^TX_DEPTH_LOG − FULL_MARGIN`.
- Reset asserted mid-drain flushes the FIFO and clears `prog_stop` immediately.

## Configuration
- Macro `IO_TX_OVERFLOW_CNT_EN`:
  - Defined: 8-bit saturating counter `ovf_cnt` increments on each dropped TX byte; reads of 0x30008 return `ovf_cnt`; reset value 0.
  - Undefined: no counter; 0x30008 reads 0x00.

## Structure
- Shared package `io_defs`: I/O page bits, offsets (0x0, 0x4, 0x8), RAM address width 17, byte width.
- One sub-module, `io_tx_fifo`: synchronous FIFO with push/pop/full/empty/count.
- All address decode and the counter live in `io_mmio_bridge`.

## Test plan
- RAM write 0x55 to 0x00100, then read 0x00100 → `ram_we` high one cycle; `cpu_din`=0x55 the cycle after the read request.
- `rx_valid`=1, `rx_data`=0x41, read 0x30000 → one-cycle `rx_pop`, `cpu_din`=0x41. Repeat with `rx_valid`=0 → 0x00, no pop.
- Write 'H','i',0x00 to 0x30000 with `tx_ready`=1 → `tx_data` emits 0x48 then 0x69; the 0x00 write is ignored.
- Read 0x30004..0x30007 across the counter boundary 0x000000FF→0x00000100 → bytes come from one coherent snapshot.
- Hold `tx_ready`=0 and write 16 bytes → `io_buffer_full` high once free slots ≤ 2; 17th byte dropped (with macro, 0x30008 reads 1).
- Write 0x30004 with 3 bytes queued → `prog_stop` rises the cycle after the trailing 0x00 is popped. `rst_in` then clears it.
